fetch_sequencer: RTL

Control block driving the `fetch` stage's PC-select port (`next_PC_select` / `target_PC`) and the instruction-memory request handshake. It boots the PC and arbitrates three redirect sources (trap, execute-stage branch, decode-stage jump) against hazard stalls. It holds the PC stable across multi-cycle memory waits and marks each returned instruction valid or squashed for decode. It sits between fetch, decode, execute, the hazard unit and instruction memory.

---
 rtl/fetch_sequencer_if.sv | 47 ++++
 rtl/fetch_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : fetch_sequencer_if
// Purpose  : Bundles the redirect sources, hazard stall, instruction-memory
//            handshake and the fetch-stage PC-select controls for
//            fetch_sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_sequencer_if #(
    parameter int ADDRESS_BITS = 16
);
    logic                    trap_valid;
    logic [ADDRESS_BITS-1:0] trap_PC;
    logic                    branch_valid;
    logic [ADDRESS_BITS-1:0] branch_target;
    logic                    jump_valid;
    logic [ADDRESS_BITS-1:0] jump_target;
    logic                    stall;
    logic                    imem_ready;
    logic                    imem_req;
    logic                    pc_enable;
    logic                    next_PC_select;
    logic [ADDRESS_BITS-1:0] target_PC;
    logic                    fetch_valid;
    logic                    flush_decode;
    logic [15:0]             redirect_count;
    logic [15:0]             stall_count;

    // Sequencer side
    modport master (
        input  trap_valid, trap_PC, branch_valid, branch_target,
        input  jump_valid, jump_target, stall, imem_ready,
        output imem_req, pc_enable, next_PC_select, target_PC,
        output fetch_valid, flush_decode, redirect_count, stall_count
    );

    // Pipeline / memory side
    modport slave (
        output trap_valid, trap_PC, branch_valid, branch_target,
        output jump_valid, jump_target, stall, imem_ready,
        input  imem_req, pc_enable, next_PC_select, target_PC,
        input  fetch_valid, flush_decode, redirect_count, stall_count
    );
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
//------------------------------------------------------------------------------
// Module   : fetch_sequencer
// Purpose  : Boots the PC, arbitrates trap > branch > jump redirects against
//            hazard stalls, holds the PC across memory waits and defers any
//            redirect that arrives while a request is unacknowledged.
//            Optional performance counters: define FETCH_SEQ_PERF_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_sequencer #(
    parameter int                    ADDRESS_BITS = 16,
    parameter logic [ADDRESS_BITS-1:0] RESET_PC   = '0
) (
    input  wire logic         clock,
    input  wire logic         reset,
    fetch_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        WAIT_MEM = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    // Redirect priority encoding: 0 = none, 1 = jump, 2 = branch, 3 = trap
    localparam logic [1:0] PRI_NONE   = 2'd0;
    localparam logic [1:0] PRI_JUMP   = 2'd1;
    localparam logic [1:0] PRI_BRANCH = 2'd2;
    localparam logic [1:0] PRI_TRAP   = 2'd3;

    state_t                  state, state_next;
    logic [1:0]              pend_pri, pend_pri_next;
    logic [ADDRESS_BITS-1:0] pend_addr, pend_addr_next;

    logic [1:0]              req_pri;
    logic [ADDRESS_BITS-1:0] req_addr;
    logic [1:0]              eff_pri;
    logic [ADDRESS_BITS-1:0] eff_addr;

    logic                    imem_req_c, pc_enable_c, select_c, fetch_valid_c, flush_c;
    logic [ADDRESS_BITS-1:0] target_c;

    // Pick the highest-priority redirect asserted this cycle
    always_comb begin
        req_pri  = PRI_NONE;
        req_addr = '0;
        if (bus.trap_valid) begin
            req_pri  = PRI_TRAP;
            req_addr = bus.trap_PC;
        end else if (bus.branch_valid) begin
            req_pri  = PRI_BRANCH;
            req_addr = bus.branch_target;
        end else if (bus.jump_valid) begin
            req_pri  = PRI_JUMP;
            req_addr = bus.jump_target;
        end
    end

    // A new redirect only displaces the pending one if strictly higher priority
    always_comb begin
        eff_pri  = pend_pri;
        eff_addr = pend_addr;
        if (req_pri > pend_pri) begin
            eff_pri  = req_pri;
            eff_addr = req_addr;
        end
    end

    // State and pending-redirect registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= BOOT;
            pend_pri  <= PRI_NONE;
            pend_addr <= '0;
        end else begin
            state     <= state_next;
            pend_pri  <= pend_pri_next;
            pend_addr <= pend_addr_next;
        end
    end

    // Next-state and control outputs; everything is forced low while in reset
    always_comb begin
        state_next     = state;
        pend_pri_next  = pend_pri;
        pend_addr_next = pend_addr;
        imem_req_c     = 1'b0;
        pc_enable_c    = 1'b0;
        select_c       = 1'b0;
        fetch_valid_c  = 1'b0;
        flush_c        = 1'b0;
        target_c       = '0;

        case (state)
            BOOT: begin
                pc_enable_c = 1'b1;
                select_c    = 1'b1;
                target_c    = RESET_PC;
                state_next  = RUN;
            end

            RUN, WAIT_MEM: begin
                imem_req_c = 1'b1;
                if (req_pri != PRI_NONE) begin
                    if (bus.imem_ready) begin
                        // Response is squashed; redirect takes effect now
                        pc_enable_c = 1'b1;
                        select_c    = 1'b1;
                        target_c    = req_addr;
                        flush_c     = 1'b1;
                        state_next  = RUN;
                    end else begin
                        // PC must not move under an outstanding request
                        pend_pri_next  = req_pri;
                        pend_addr_next = req_addr;
                        state_next     = DRAIN;
                    end
                end else if (bus.imem_ready) begin
                    state_next = RUN;
                    if (!bus.stall) begin
                        fetch_valid_c = 1'b1;
                        pc_enable_c   = 1'b1;
                    end
                end else begin
                    state_next = WAIT_MEM;
                end
            end

            DRAIN: begin
                imem_req_c     = 1'b1;
                pend_pri_next  = eff_pri;
                pend_addr_next = eff_addr;
                if (bus.imem_ready) begin
                    pc_enable_c    = 1'b1;
                    select_c       = 1'b1;
                    target_c       = eff_addr;
                    flush_c        = 1'b1;
                    pend_pri_next  = PRI_NONE;
                    pend_addr_next = '0;
                    state_next     = RUN;
                end
            end

            default: state_next = BOOT;
        endcase

        if (!reset) begin
            imem_req_c    = 1'b0;
            pc_enable_c   = 1'b0;
            select_c      = 1'b0;
            fetch_valid_c = 1'b0;
            flush_c       = 1'b0;
            target_c      = '0;
        end
    end

    assign bus.imem_req       = imem_req_c;
    assign bus.pc_enable      = pc_enable_c;
    assign bus.next_PC_select = select_c;
    assign bus.target_PC      = target_c;
    assign bus.fetch_valid    = fetch_valid_c;
    assign bus.flush_decode   = flush_c;

`ifdef FETCH_SEQ_PERF_EN
    logic        redirect_hit;
    logic        stall_hit;
    logic [15:0] redirect_cnt;
    logic [15:0] stall_cnt;

    // Any PC load from target_PC outside BOOT is an applied redirect
    assign redirect_hit = pc_enable_c & select_c & (state != BOOT);
    assign stall_hit    = reset & ((state == RUN) || (state == WAIT_MEM)) &
                          bus.imem_ready & bus.stall & (req_pri == PRI_NONE);

    // Saturating event counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (redirect_hit && (redirect_cnt != 16'hFFFF)) begin
                redirect_cnt <= redirect_cnt + 16'd1;
            end
            if (stall_hit && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    assign bus.redirect_count = redirect_cnt;
    assign bus.stall_count    = stall_cnt;
`else
    assign bus.redirect_count = 16'd0;
    assign bus.stall_count    = 16'd0;
`endif

endmodule

`default_nettype wire
